// File: rtl/l2_line_responder_if.sv
// Bundle between the instruction-cache miss port, the L2 line responder and the memory read port.
// The slave modport is the responder's view; master is the requester/memory side.
interface l2_line_responder_if #(
   parameter int unsigned data_width    = 32,
   parameter int unsigned address_width = 32,
   parameter int unsigned block_size    = 32
);
   localparam int unsigned offset_width = $clog2(data_width * block_size / 8);
   localparam int unsigned cache_width  = block_size * data_width;

   logic                                  addr_to_l2_valid;
   logic [address_width-offset_width-1:0] addr_to_l2;
   logic                                  flush;
   logic [cache_width-1:0]                data_from_l2;
   logic                                  data_from_l2_valid;
   logic                                  busy;
   logic                                  mem_rd_valid;
   logic [address_width-1:0]              mem_rd_addr;
   logic                                  mem_rd_ready;
   logic [data_width-1:0]                 mem_rd_data;
   logic                                  mem_rd_data_valid;

   modport slave (
      input  addr_to_l2_valid, addr_to_l2, flush, mem_rd_ready, mem_rd_data, mem_rd_data_valid,
      output data_from_l2, data_from_l2_valid, busy, mem_rd_valid, mem_rd_addr
   );

   modport master (
      output addr_to_l2_valid, addr_to_l2, flush, mem_rd_ready, mem_rd_data, mem_rd_data_valid,
      input  data_from_l2, data_from_l2_valid, busy, mem_rd_valid, mem_rd_addr
   );
endinterface

// File: rtl/l2_line_responder.sv
// L2-side responder: fetches one cache line word-by-word over a pipelined in-order memory read
// port, assembles it and returns the whole line in a single-cycle pulse.
module l2_line_responder #(
   parameter int unsigned data_width      = 32,
   parameter int unsigned address_width   = 32,
   parameter int unsigned block_size      = 32,
   parameter int unsigned max_outstanding = 4
) (
   input logic               clk,
   input logic               rstn,
   l2_line_responder_if.slave bus
);
   localparam int unsigned offset_width = $clog2(data_width * block_size / 8);
   localparam int unsigned line_width   = address_width - offset_width;
   localparam int unsigned idx_width    = $clog2(block_size);
   localparam int unsigned byte_width   = $clog2(data_width / 8);
   localparam int unsigned cnt_width    = idx_width + 1;
   localparam int unsigned cache_width  = block_size * data_width;

   localparam logic [cnt_width-1:0] block_cnt = cnt_width'(block_size);
   // A limit above the line length can never be reached, so clamp it to fit the counters.
   localparam logic [cnt_width-1:0] max_out =
      (max_outstanding >= block_size) ? block_cnt : cnt_width'(max_outstanding);

   typedef enum logic [1:0] {StIdle, StFetch, StDone, StDrain} state_e;

   state_e                 state_q;
   logic [line_width-1:0]  line_q;
   logic [cnt_width-1:0]   issued_q;
   logic [cnt_width-1:0]   resp_q;
   logic [cache_width-1:0] buf_q;
   logic [cache_width-1:0] data_q;
   logic                   valid_q;

   logic [cnt_width-1:0]   outstanding;
   logic [idx_width-1:0]   resp_idx;
   logic [cache_width-1:0] buf_next;
   logic                   issue_ok;
   logic                   accept;
   logic                   ret;

   always_comb begin
      outstanding = issued_q - resp_q;
      issue_ok    = (state_q == StFetch) && !bus.flush && (issued_q < block_cnt) &&
                    (outstanding < max_out);
      accept      = issue_ok && bus.mem_rd_ready;
      ret         = bus.mem_rd_data_valid;
      resp_idx    = resp_q[idx_width-1:0];
      buf_next    = buf_q;
      buf_next[resp_idx*data_width +: data_width] = bus.mem_rd_data;
   end

   assign bus.mem_rd_valid       = issue_ok;
   assign bus.mem_rd_addr        = {line_q, issued_q[idx_width-1:0], {byte_width{1'b0}}};
   assign bus.busy               = (state_q != StIdle);
   assign bus.data_from_l2       = data_q;
   assign bus.data_from_l2_valid = valid_q;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q  <= StIdle;
         line_q   <= '0;
         issued_q <= '0;
         resp_q   <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.addr_to_l2_valid) begin
                  line_q   <= bus.addr_to_l2;
                  issued_q <= '0;
                  resp_q   <= '0;
                  state_q  <= StFetch;
               end
            end
            StFetch: begin
               if (accept) issued_q <= issued_q + 1'b1;
               if (ret)    resp_q   <= resp_q + 1'b1;
               if (bus.flush) begin
                  // A return landing in the flush cycle already counts toward draining.
                  state_q <= (outstanding == cnt_width'(ret)) ? StIdle : StDrain;
               end else if (ret) begin
                  buf_q <= buf_next;
                  if (resp_q == block_cnt - 1'b1) begin
                     data_q  <= buf_next;
                     valid_q <= 1'b1;
                     state_q <= StDone;
                  end
               end
            end
            StDone: state_q <= StIdle;
            StDrain: begin
               if (ret) begin
                  resp_q <= resp_q + 1'b1;
                  if (outstanding == cnt_width'(1)) state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end
endmodule

// File: tb/tb_l2_line_responder.sv
// Scoreboard bench for l2_line_responder: a latency-configurable memory model answers reads and
// every returned line is popped from the queue of expected lines and compared word by word.
module tb_l2_line_responder;
   localparam int unsigned data_width      = 32;
   localparam int unsigned address_width   = 32;
   localparam int unsigned block_size      = 32;
   localparam int unsigned max_outstanding = 4;

   typedef struct {
      logic [24:0] ln;
      int          cyc;
      bit          chk_lat;
   } sb_t;

   typedef struct {
      int          due;
      logic [31:0] addr;
   } rd_t;

   logic        clk;
   logic        rstn;
   sb_t         sb[$];
   rd_t         pend[$];
   int          n_checks = 0;
   int          n_fails = 0;
   int          cyc = 0;
   int          lat = 1;
   int          last_ret_cyc = 0;
   int          n_iss = 0;
   bit          half_ready = 1'b0;
   logic [24:0] cur_line = '0;

   l2_line_responder_if #(
      .data_width   (data_width),
      .address_width(address_width),
      .block_size   (block_size)
   ) bus ();

   l2_line_responder #(
      .data_width     (data_width),
      .address_width  (address_width),
      .block_size     (block_size),
      .max_outstanding(max_outstanding)
   ) dut (
      .clk (clk),
      .rstn(rstn),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100_000;
      $display("FAIL watchdog: got no end of test, required completion within 100 us");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return {8'h00, addr[25:2]};
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Memory model and output monitor; drives at negedge, samples 2 ns later.
   initial begin : mem_model
      rd_t         r;
      sb_t         e;
      logic        dl;
      logic        stall;
      logic [31:0] stall_addr;
      stall                 = 1'b0;
      stall_addr            = '0;
      bus.mem_rd_ready      = 1'b1;
      bus.mem_rd_data_valid = 1'b0;
      bus.mem_rd_data       = '0;
      forever begin
         @(negedge clk);
         cyc++;
         dl = 1'b0;
         if (pend.size() > 0 && pend[0].due <= cyc) begin
            r            = pend.pop_front();
            dl           = 1'b1;
            last_ret_cyc = cyc;
         end
         bus.mem_rd_data_valid = dl;
         bus.mem_rd_data       = dl ? mem_word(r.addr) : $urandom();
         bus.mem_rd_ready      = half_ready ? cyc[0] : 1'b1;
         #2;
         if (stall && rstn && !bus.flush) begin
            check("stall_valid_held", 64'(bus.mem_rd_valid), 64'(1));
            check("stall_addr_held", 64'(bus.mem_rd_addr), 64'(stall_addr));
         end
         stall      = rstn && bus.mem_rd_valid && !bus.mem_rd_ready;
         stall_addr = bus.mem_rd_addr;
         if (bus.mem_rd_valid && bus.mem_rd_ready) begin
            check("outstanding_cap", 64'((pend.size() + int'(dl)) < max_outstanding), 64'(1));
            check("rd_addr", 64'(bus.mem_rd_addr), 64'({cur_line, 7'd0} + 32'(n_iss * 4)));
            pend.push_back('{due: cyc + lat, addr: bus.mem_rd_addr});
            n_iss++;
         end
         if (bus.data_from_l2_valid) begin
            check("line_pulse_expected", 64'(sb.size() > 0), 64'(1));
            if (sb.size() > 0) begin
               e = sb.pop_front();
               if (e.chk_lat) check("line_latency", 64'(cyc - e.cyc), 64'(34));
               for (int i = 0; i < block_size; i++) begin
                  check($sformatf("line_%0h_word%0d", e.ln, i), 64'(bus.data_from_l2[i*32 +: 32]),
                        64'(mem_word({e.ln, 7'd0} + 32'(i * 4))));
               end
            end
         end
      end
   end

   task automatic next();
      @(negedge clk);
      #1;
   endtask

   task automatic req(input logic [24:0] ln, input bit take, input bit expect_line,
                      input bit chk_lat);
      next();
      bus.addr_to_l2_valid = 1'b1;
      bus.addr_to_l2       = ln;
      if (take) begin
         cur_line = ln;
         n_iss    = 0;
      end
      if (expect_line) sb.push_back('{ln: ln, cyc: cyc, chk_lat: chk_lat});
      next();
      bus.addr_to_l2_valid = 1'b0;
   endtask

   task automatic wait_pulse(input string tag, input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         next();
         seen = bus.data_from_l2_valid;
      end
      check({tag, "_pulse_seen"}, 64'(seen), 64'(1));
   endtask

   task automatic wait_iss(input string tag, input int target, input int budget);
      for (int i = 0; i < budget && n_iss < target; i++) next();
      check({tag, "_issue_reached"}, 64'(n_iss >= target), 64'(1));
   endtask

   task automatic wait_idle(input string tag, input int budget);
      for (int i = 0; i < budget && bus.busy; i++) next();
      check({tag, "_idle_reached"}, 64'(bus.busy), 64'(0));
   endtask

   initial begin : main
      rstn                 = 1'b0;
      bus.addr_to_l2_valid = 1'b0;
      bus.addr_to_l2       = '0;
      bus.flush            = 1'b0;
      repeat (3) next();
      check("rst_busy", 64'(bus.busy), 64'(0));
      check("rst_rd_valid", 64'(bus.mem_rd_valid), 64'(0));
      check("rst_line_valid", 64'(bus.data_from_l2_valid), 64'(0));
      check("rst_line_data", 64'(|bus.data_from_l2), 64'(0));
      rstn = 1'b1;
      next();

      // Full-rate fetch, minimum latency
      lat        = 1;
      half_ready = 1'b0;
      req(25'h100_0000, 1'b1, 1'b1, 1'b1);
      wait_pulse("t1", 60);
      next();
      check("t1_busy_after_done", 64'(bus.busy), 64'(0));

      // Stalling memory port, longer latency
      lat        = 6;
      half_ready = 1'b1;
      req(25'h100_0002, 1'b1, 1'b1, 1'b0);
      wait_pulse("t2", 200);

      // Long latency so the outstanding limit is the throttle
      lat        = 12;
      half_ready = 1'b0;
      req(25'h001_0000, 1'b1, 1'b1, 1'b0);
      wait_pulse("t2b", 300);

      // Flush mid-line: no pulse, drain until the last in-flight return
      lat = 6;
      req(25'h100_0000, 1'b1, 1'b0, 1'b0);
      wait_iss("t3", 10, 100);
      bus.flush = 1'b1;
      #2;
      check("flush_stops_issue", 64'(bus.mem_rd_valid), 64'(0));
      next();
      bus.flush = 1'b0;
      check("t3_draining_busy", 64'(bus.busy), 64'(pend.size() > 0));
      wait_idle("t3", 50);
      check("drain_exit_cycle", 64'(cyc), 64'(last_ret_cyc + 1));
      check("drain_pend_empty", 64'(pend.size()), 64'(0));
      lat = 1;
      req(25'h100_0001, 1'b1, 1'b1, 1'b0);
      wait_pulse("t3_next", 60);

      // Reset mid-fetch; stray returns must be ignored
      lat = 3;
      req(25'h000_1234, 1'b1, 1'b0, 1'b0);
      wait_iss("t4", 5, 50);
      rstn = 1'b0;
      next();
      check("t4_rst_busy", 64'(bus.busy), 64'(0));
      check("t4_rst_rd_valid", 64'(bus.mem_rd_valid), 64'(0));
      check("t4_rst_line_valid", 64'(bus.data_from_l2_valid), 64'(0));
      check("t4_rst_line_data", 64'(|bus.data_from_l2), 64'(0));
      rstn = 1'b1;
      for (int i = 0; i < 20 && pend.size() > 0; i++) begin
         next();
         check("t4_stray_busy", 64'(bus.busy), 64'(0));
         check("t4_stray_rd_valid", 64'(bus.mem_rd_valid), 64'(0));
      end
      next();
      req(25'h000_1235, 1'b1, 1'b1, 1'b0);
      wait_pulse("t4", 80);

      // A second request during fetch is ignored
      lat = 2;
      req(25'h0AB_CDEF, 1'b1, 1'b1, 1'b0);
      wait_iss("t5", 3, 50);
      bus.addr_to_l2_valid = 1'b1;
      bus.addr_to_l2       = 25'h155_5555;
      next();
      bus.addr_to_l2_valid = 1'b0;
      wait_pulse("t5", 100);

      // Back-to-back request in the cycle right after the pulse
      req(25'h0AB_CDF0, 1'b1, 1'b1, 1'b0);
      wait_pulse("t6", 100);

      repeat (5) next();
      check("sb_empty", 64'(sb.size()), 64'(0));
      check("mem_pend_empty", 64'(pend.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
